// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, configurable word size, parity and stop bits.
// Frames are sent back-to-back for as long as the FIFO holds words.
module uart_tx_fifo #(
  parameter int ClkRate   = 100_000_000,
  parameter int BaudRate  = 115200,
  parameter int WordSize  = 8,
  parameter int Parity    = 0,
  parameter int StopBits  = 1,
  parameter int FifoDepth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [WordSize-1:0]            data_i,
  input  logic                           data_valid_i,
  output logic                           data_ack_o,
  output logic                           uart_o,
  output logic                           busy_o,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_level_o
);

  localparam int   BaudDiv = ClkRate / BaudRate;
  localparam int   CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam int   PtrW    = $clog2(FifoDepth);
  localparam int   LvlW    = $clog2(FifoDepth + 1);
  localparam int   BitW    = $clog2(WordSize);
  localparam logic OddPar  = (Parity == 1);

  if (WordSize < 5 || WordSize > 9) begin : g_bad_word_size
    $error("uart_tx_fifo: WordSize must be in 5..9");
  end
  if (Parity < 0 || Parity > 2) begin : g_bad_parity
    $error("uart_tx_fifo: Parity must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FifoDepth must be a power of two >= 2");
  end
  if (BaudDiv < 1) begin : g_bad_baud
    $error("uart_tx_fifo: ClkRate / BaudRate must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Handshake: the producer holds data_i/data_valid_i until data_ack_o; a word
  // transfers on every rising edge where data_ack_o is high (valid & !full).
  logic [WordSize-1:0] mem [FifoDepth];
  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [LvlW-1:0]     level;
  logic                full, empty, push, pop;
  logic [WordSize-1:0] head;

  state_t              state;
  logic [CntW-1:0]     baud_cnt;
  logic [BitW-1:0]     bit_idx;
  logic                stop_idx;
  logic [WordSize-1:0] shift_q;
  logic                par_q;
  logic                baud_end, last_stop;

  assign full       = (level == LvlW'(FifoDepth));
  assign empty      = (level == '0);
  assign data_ack_o = data_valid_i & ~full & rst_ni;
  assign push       = data_ack_o;
  assign head       = mem[rd_ptr];

  assign baud_end  = (baud_cnt == CntW'(BaudDiv - 1));
  assign last_stop = (state == S_STOP) && baud_end && (stop_idx == 1'(StopBits - 1));
  // Fullness is taken before the pop, so a full FIFO never accepts a write-through.
  assign pop       = ~empty & ((state == S_IDLE) | last_stop);

  assign busy_o       = (state != S_IDLE) | ~empty;
  assign fifo_level_o = level;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   level <= level + LvlW'(1);
        2'b01:   level <= level - LvlW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      uart_o   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          uart_o   <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_q <= head;
            par_q   <= (^head) ^ OddPar;
            uart_o  <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_o   <= shift_q[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CntW'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == BitW'(WordSize - 1)) begin
              if (Parity != 0) begin
                uart_o <= par_q;
                state  <= S_PARITY;
              end else begin
                uart_o   <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              // LSB goes first; the next bit is always sitting in shift_q[1].
              bit_idx <= bit_idx + BitW'(1);
              shift_q <= shift_q >> 1;
              uart_o  <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CntW'(1);
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            uart_o   <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CntW'(1);
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (last_stop) begin
              // Chain straight into the next start bit when a word is waiting.
              if (pop) begin
                shift_q <= head;
                par_q   <= (^head) ^ OddPar;
                uart_o  <= 1'b0;
                state   <= S_START;
              end else begin
                uart_o <= 1'b1;
                state  <= S_IDLE;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CntW'(1);
          end
        end
        default: begin
          uart_o   <= 1'b1;
          baud_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
